// File: rtl/rtc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rtc_pkg                                                         |
// | Brief    : Shared seven-segment codes, time limits and helpers for the RTC.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package rtc_pkg;

  // Segment order a..g in bits 6..0; 1 = lit.
  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned HOUR_MAX = 23;
  localparam int unsigned HOUR12   = 12;

  typedef struct packed {
    logic [4:0] hour;
    logic [2:0] min_m;
    logic [3:0] min_l;
    logic [2:0] sec_m;
    logic [3:0] sec_l;
  } rtc_time_t;

  // True when a tens/units BCD pair equals the given decimal limit.
  function automatic logic bcd_at(input logic [2:0] tens, input logic [3:0] units,
                                  input int unsigned limit);
    return ({29'd0, tens} * 32'd10 + {28'd0, units}) == limit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_7seg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bcd_to_7seg                                                     |
// | Brief    : BCD digit to seven-segment code; inverted when                  |
// |            RTC_SEG_ACTIVE_LOW_EN is defined (common-anode displays).       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module bcd_to_7seg
  import rtc_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  logic [6:0] w_seg;

  always_comb begin
    w_seg = SEG_BLANK;
    case (digit_i)
      4'd0:    w_seg = SEG_0;
      4'd1:    w_seg = SEG_1;
      4'd2:    w_seg = SEG_2;
      4'd3:    w_seg = SEG_3;
      4'd4:    w_seg = SEG_4;
      4'd5:    w_seg = SEG_5;
      4'd6:    w_seg = SEG_6;
      4'd7:    w_seg = SEG_7;
      4'd8:    w_seg = SEG_8;
      4'd9:    w_seg = SEG_9;
      default: w_seg = SEG_BLANK;
    endcase
  end

`ifdef RTC_SEG_ACTIVE_LOW_EN
  assign seg_o = ~w_seg;
`else
  assign seg_o = w_seg;
`endif

endmodule
`default_nettype wire

// File: rtl/real_time_digital_clock.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : real_time_digital_clock                                         |
// | Brief    : 1 Hz HH:MM:SS counter with 12/24-hour seven-segment display.    |
// |            Optional macro RTC_SEG_ACTIVE_LOW_EN inverts all segment codes. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module real_time_digital_clock
  import rtc_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       format_ctrl,
  output logic [6:0] HRM,
  output logic [6:0] HRL,
  output logic [6:0] MIN_M,
  output logic [6:0] MIN_L,
  output logic [6:0] SEC_M,
  output logic [6:0] SEC_L
);

  rtc_time_t time_q, time_d;
  logic      w_sec_max, w_min_max, w_hour_max;

  assign w_sec_max  = bcd_at(time_q.sec_m, time_q.sec_l, SEC_MAX);
  assign w_min_max  = bcd_at(time_q.min_m, time_q.min_l, MIN_MAX);
  assign w_hour_max = ({27'd0, time_q.hour} == HOUR_MAX);

  always_comb begin
    time_d = time_q;
    if (w_sec_max) begin
      time_d.sec_l = 4'd0;
      time_d.sec_m = 3'd0;
    end else if (time_q.sec_l == 4'd9) begin
      time_d.sec_l = 4'd0;
      time_d.sec_m = time_q.sec_m + 3'd1;
    end else begin
      time_d.sec_l = time_q.sec_l + 4'd1;
    end

    // Minutes advance in the same edge that seconds roll over.
    if (w_sec_max) begin
      if (w_min_max) begin
        time_d.min_l = 4'd0;
        time_d.min_m = 3'd0;
        time_d.hour  = w_hour_max ? 5'd0 : time_q.hour + 5'd1;
      end else if (time_q.min_l == 4'd9) begin
        time_d.min_l = 4'd0;
        time_d.min_m = time_q.min_m + 3'd1;
      end else begin
        time_d.min_l = time_q.min_l + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) time_q <= '0;
    else     time_q <= time_d;
  end

  // Display hour; the stored count always stays in 24-hour form.
  logic [4:0] w_hour_disp;
  logic [3:0] w_hr_tens, w_hr_units;

  always_comb begin
    w_hour_disp = time_q.hour;
    if (!format_ctrl) begin
      if (time_q.hour == 5'd0)              w_hour_disp = 5'(HOUR12);
      else if (time_q.hour > 5'(HOUR12))    w_hour_disp = time_q.hour - 5'(HOUR12);
    end
    w_hr_tens  = 4'd0;
    w_hr_units = w_hour_disp[3:0];
    if (w_hour_disp >= 5'd20) begin
      w_hr_tens  = 4'd2;
      w_hr_units = 4'(w_hour_disp - 5'd20);
    end else if (w_hour_disp >= 5'd10) begin
      w_hr_tens  = 4'd1;
      w_hr_units = 4'(w_hour_disp - 5'd10);
    end
  end

  logic [3:0] w_digit [6];
  logic [6:0] w_seg   [6];

  assign w_digit[0] = w_hr_tens;
  assign w_digit[1] = w_hr_units;
  assign w_digit[2] = {1'b0, time_q.min_m};
  assign w_digit[3] = time_q.min_l;
  assign w_digit[4] = {1'b0, time_q.sec_m};
  assign w_digit[5] = time_q.sec_l;

  for (genvar gi = 0; gi < 6; gi++) begin : g_seg
    bcd_to_7seg u_dec (
      .digit_i (w_digit[gi]),
      .seg_o   (w_seg[gi])
    );
  end

  assign HRM   = w_seg[0];
  assign HRL   = w_seg[1];
  assign MIN_M = w_seg[2];
  assign MIN_L = w_seg[3];
  assign SEC_M = w_seg[4];
  assign SEC_L = w_seg[5];

endmodule
`default_nettype wire

// File: tb/tb_real_time_digital_clock.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_real_time_digital_clock                                      |
// | Brief    : Directed self-checking bench for real_time_digital_clock.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_real_time_digital_clock;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       format_ctrl = 1'b1;
  logic [6:0] HRM, HRL, MIN_M, MIN_L, SEC_M, SEC_L;

  int n_checks = 0;
  int n_errors = 0;

  real_time_digital_clock dut (
    .CLK         (CLK),
    .RST         (RST),
    .format_ctrl (format_ctrl),
    .HRM         (HRM),
    .HRL         (HRL),
    .MIN_M       (MIN_M),
    .MIN_L       (MIN_L),
    .SEC_M       (SEC_M),
    .SEC_L       (SEC_L)
  );

  always #5 CLK = ~CLK;

  function automatic logic [6:0] enc(input int d);
    logic [6:0] c;
    case (d)
      0: c = 7'h7E;  1: c = 7'h30;  2: c = 7'h6D;  3: c = 7'h79;  4: c = 7'h33;
      5: c = 7'h5B;  6: c = 7'h5F;  7: c = 7'h70;  8: c = 7'h7F;  9: c = 7'h7B;
      default: c = 7'h00;
    endcase
`ifdef RTC_SEG_ACTIVE_LOW_EN
    return ~c;
`else
    return c;
`endif
  endfunction

  task automatic check_eq(input string tag, input logic [41:0] got, input logic [41:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_time(input string tag, input int h1, input int h0, input int m1,
                            input int m0, input int s1, input int s0);
    check_eq(tag, {HRM, HRL, MIN_M, MIN_L, SEC_M, SEC_L},
             {enc(h1), enc(h0), enc(m1), enc(m0), enc(s1), enc(s0)});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    #12;
    check_time("reset_24h", 0, 0, 0, 0, 0, 0);
    format_ctrl = 1'b0; #1;
    check_time("reset_12h", 1, 2, 0, 0, 0, 0);
    format_ctrl = 1'b1;
    @(negedge CLK); RST = 1'b0; #1;
    check_time("released_no_edge", 0, 0, 0, 0, 0, 0);

    tick(59);                                    // 59 s
    check_time("t_00_00_59", 0, 0, 0, 0, 5, 9);
    tick(1);                                     // 60 s
    check_time("t_00_01_00", 0, 0, 0, 1, 0, 0);
    tick(3540);                                  // 3600 s
    check_time("t_01_00_00", 0, 1, 0, 0, 0, 0);
    tick(39600);                                 // 43200 s
    check_time("t_12_00_00_24h", 1, 2, 0, 0, 0, 0);
    format_ctrl = 1'b0; #1;
    check_time("t_12_00_00_12h", 1, 2, 0, 0, 0, 0);
    format_ctrl = 1'b1;
    tick(3900);                                  // 47100 s
    check_time("t_13_05_00_24h", 1, 3, 0, 5, 0, 0);
    format_ctrl = 1'b0; #1;
    check_time("t_13_05_00_12h", 0, 1, 0, 5, 0, 0);
    tick(1);                                     // 47101 s
    check_time("t_13_05_01_12h", 0, 1, 0, 5, 0, 1);
    format_ctrl = 1'b1; #1;
    check_time("t_13_05_01_24h", 1, 3, 0, 5, 0, 1);
    tick(39298);                                 // 86399 s
    check_time("t_23_59_59_24h", 2, 3, 5, 9, 5, 9);
    format_ctrl = 1'b0; #1;
    check_time("t_23_59_59_12h", 1, 1, 5, 9, 5, 9);
    format_ctrl = 1'b1;
    tick(1);                                     // 86400 s
    check_time("wrap_00_00_00", 0, 0, 0, 0, 0, 0);
    format_ctrl = 1'b0; #1;
    check_time("wrap_12h", 1, 2, 0, 0, 0, 0);
    format_ctrl = 1'b1;

    tick(607);
    check_time("t_00_10_07", 0, 0, 1, 0, 0, 7);
    #1 RST = 1'b1; #1;                           // between edges
    check_time("async_reset_24h", 0, 0, 0, 0, 0, 0);
    format_ctrl = 1'b0; #1;
    check_time("async_reset_12h", 1, 2, 0, 0, 0, 0);
    format_ctrl = 1'b1;
    tick(2);
    check_time("held_in_reset", 0, 0, 0, 0, 0, 0);
    @(negedge CLK); RST = 1'b0;
    tick(1);
    check_time("first_edge_after_reset", 0, 0, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/real_time_digital_clock.md
REAL_TIME_DIGITAL_CLOCK -- requirements
Module: real_time_digital_clock

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; each rising edge is one second tick.
REQ-002 SHALL have port RST, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port format_ctrl, input, 1 bit: 1 = 24-hour display, 0 = 12-hour display.
REQ-004 SHALL have ports HRM, HRL, input-derived outputs, 7 bits each: hour tens / units seven-segment codes.
REQ-005 SHALL have ports MIN_M, MIN_L, outputs, 7 bits each: minute tens / units seven-segment codes.
REQ-006 SHALL have ports SEC_M, SEC_L, outputs, 7 bits each: second tens / units seven-segment codes.
REQ-007 SHALL use segment bit order bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g; 1 = segment lit (default build).

Function
REQ-008 SHALL keep internal time always in 24-hour form: sec_l 0-9, sec_m 0-5, min_l 0-9, min_m 0-5, hour 0-23.
REQ-009 SHALL increment seconds by one on every rising CLK edge while RST is low.
REQ-010 SHALL wrap sec 59 -> 00 and increment minutes in that same edge; min 59 -> 00 increments hour in the same edge.
REQ-011 SHALL wrap 23:59:59 -> 00:00:00 on the next edge.
REQ-012 SHALL derive all outputs combinationally from registered counters and format_ctrl; format change takes effect immediately, never alters the count.
REQ-013 SHALL in 24-hour mode display hour 0-23 as two decimal digits (00-23).
REQ-014 SHALL in 12-hour mode display hour 0 as 12, 1-12 unchanged, 13-23 as hour-12 (01-11); no AM/PM output; leading zero shown.
REQ-015 SHALL encode digits: 0=7E,1=30,2=6D,3=79,4=33,5=5B,6=5F,7=70,8=7F,9=7B (hex); any unused code -> 00 (blank).
REQ-016 SHALL have latency zero from counter state to outputs; counter state updates one edge per second.

Reset
REQ-017 SHALL on RST high asynchronously clear all counters to 00:00:00, regardless of CLK.
REQ-018 SHALL during reset output 00:00:00 codes in 24-hour mode and 12:00:00 codes in 12-hour mode.
REQ-019 SHALL count the first second on the first rising CLK edge after RST deasserts; reset mid-count returns to 00:00:00 immediately.

Configuration
REQ-020 SHALL support macro RTC_SEG_ACTIVE_LOW_EN: when defined, all six outputs are bitwise-inverted (common-anode, 0 = lit; blank = 7F); when undefined, active-high per REQ-007/REQ-015.

Structure
REQ-021 SHALL place in shared package rtc_pkg: seven-segment digit constants, blank code, limits (SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, HOUR12=12).
REQ-022 SHALL instantiate six copies of sub-module bcd_to_7seg (4-bit digit in, 7-bit code out, honours RTC_SEG_ACTIVE_LOW_EN).
REQ-023 SHALL contain hour-format conversion and counters in real_time_digital_clock itself.

Verification
REQ-024 Reset, format_ctrl=1, 59 edges -> SEC_M=5B, SEC_L=7B, others 7E; 60th edge -> MIN_L=30, SEC_M=SEC_L=7E.
REQ-025 Reset, 3600 edges, format_ctrl=1 -> HRM=7E, HRL=30, MIN/SEC all 7E (01:00:00).
REQ-026 Reset, 86399 edges -> 23:59:59 (6D,79,5B,7B,5B,7B); 86400th edge -> all 7E (00:00:00).
REQ-027 Reset, 47100 edges (13:05:00): format_ctrl=1 -> HRM=30, HRL=79; toggle to 0 without an edge -> HRM=7E, HRL=30; MIN_L=5B; count continues unchanged.
REQ-028 format_ctrl=0 after reset -> HRM=30, HRL=6D (12); 43200 edges -> still 12:00:00.
REQ-029 Assert RST asynchronously between edges at 00:10:07 -> outputs 00:00:00 before next CLK edge; with RTC_SEG_ACTIVE_LOW_EN defined, same scenarios pass with inverted codes (0 -> 01).
